// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - start/stop/lap/clear stopwatch controller with BCD MM:SS count
module stopwatch_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int PW       = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic [3:0] min_t,
    output logic [3:0] min_o,
    output logic [3:0] sec_t,
    output logic [3:0] sec_o,
    output logic       running,
    output logic       lap_active,
    output logic       wrap
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LAP   = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [15:0]   live, live_n, live_inc;
    logic [15:0]   snap, snap_n;
    logic [2:0]    btn_q;      // {clear, start, lap}
    logic [2:0]    press_q;
    logic          run_like, tick, wrap_n;
    logic          do_clear, do_start, do_lap;

    assign run_like = (state == S_RUN) || (state == S_LAP);
    assign tick     = run_like && (presc == PW'(TICK_DIV - 1));

    // Only the highest-priority registered press is acted on.
    assign do_clear = press_q[2];
    assign do_start = press_q[1] && !press_q[2];
    assign do_lap   = press_q[0] && !press_q[1] && !press_q[2];

    always_comb begin
        live_inc = live;
        if (live[3:0] == 4'd9) begin
            live_inc[3:0] = 4'd0;
            if (live[7:4] == 4'd5) begin
                live_inc[7:4] = 4'd0;
                if (live[11:8] == 4'd9) begin
                    live_inc[11:8]  = 4'd0;
                    live_inc[15:12] = (live[15:12] == 4'd5) ? 4'd0 : live[15:12] + 4'd1;
                end else begin
                    live_inc[11:8] = live[11:8] + 4'd1;
                end
            end else begin
                live_inc[7:4] = live[7:4] + 4'd1;
            end
        end else begin
            live_inc[3:0] = live[3:0] + 4'd1;
        end
    end

    always_comb begin
        state_n = state;
        snap_n  = snap;
        live_n  = tick ? live_inc : live;
        wrap_n  = tick && (live == 16'h5959);
        presc_n = presc;
        case (state)
            S_IDLE: begin
                presc_n = '0;
                if (do_start) state_n = S_RUN;
            end
            S_RUN: begin
                presc_n = tick ? '0 : presc + PW'(1);
                if (do_start) begin
                    state_n = S_PAUSE;
                end else if (do_lap) begin
                    state_n = S_LAP;
                    snap_n  = live;
                end
            end
            S_PAUSE: begin
                if (do_start) begin
                    state_n = S_RUN;
                end else if (do_clear) begin
                    state_n = S_IDLE;
                    live_n  = '0;
                    presc_n = '0;
                end
            end
            S_LAP: begin
                presc_n = tick ? '0 : presc + PW'(1);
                if (do_lap) state_n = S_RUN;
                else if (do_start) state_n = S_PAUSE;
            end
            default: begin
                state_n = S_IDLE;
                presc_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            presc      <= '0;
            live       <= '0;
            snap       <= '0;
            btn_q      <= '0;
            press_q    <= '0;
            min_t      <= '0;
            min_o      <= '0;
            sec_t      <= '0;
            sec_o      <= '0;
            running    <= 1'b0;
            lap_active <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            btn_q   <= {btn_clear, btn_start, btn_lap};
            press_q <= {btn_clear, btn_start, btn_lap} & ~btn_q;
            state   <= state_n;
            presc   <= presc_n;
            live    <= live_n;
            snap    <= snap_n;
            // Outputs are derived from next-state values so they move with the state.
            {min_t, min_o, sec_t, sec_o} <= (state_n == S_LAP) ? snap_n : live_n;
            running    <= (state_n == S_RUN) || (state_n == S_LAP);
            lap_active <= (state_n == S_LAP);
            wrap       <= wrap_n;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl with TICK_DIV=4
module tb_stopwatch_ctrl;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset, btn_start, btn_lap, btn_clear;
    logic [3:0] min_t, min_o, sec_t, sec_o;
    logic       running, lap_active, wrap;

    stopwatch_ctrl #(.TICK_DIV(TD), .PW(3)) dut (
        .clk(clk), .reset(reset),
        .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
        .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o),
        .running(running), .lap_active(lap_active), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] digits;
        logic        running;
        logic        lap_active;
        logic        wrap;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Reference model: count kept as plain seconds, converted to BCD for comparison.
    int   m_st = 0, m_presc = 0, m_cnt = 0, m_snap = 0;
    logic m_hs = 0, m_hl = 0, m_hc = 0, m_ps = 0, m_pl = 0, m_pc = 0;

    function automatic logic [15:0] to_bcd(input int c);
        logic [15:0] r;
        r[15:12] = 4'(c / 600);
        r[11:8]  = 4'((c / 60) % 10);
        r[7:4]   = 4'((c % 60) / 10);
        r[3:0]   = 4'(c % 10);
        return r;
    endfunction

    function automatic logic [15:0] dut_digits();
        return {min_t, min_o, sec_t, sec_o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic s, input logic l, input logic c, input logic r);
        int   ns, np, nc, nsn;
        logic tk, ds, dl, dc, nw;
        exp_t e;
        if (r) begin
            m_st = 0; m_presc = 0; m_cnt = 0; m_snap = 0;
            m_hs = 0; m_hl = 0; m_hc = 0; m_ps = 0; m_pl = 0; m_pc = 0;
            e = '0;
        end else begin
            tk  = (m_st == 1 || m_st == 3) && (m_presc == TD - 1);
            dc  = m_pc;
            ds  = m_ps && !m_pc;
            dl  = m_pl && !m_ps && !m_pc;
            ns  = m_st;
            nsn = m_snap;
            nc  = tk ? (m_cnt + 1) % 3600 : m_cnt;
            nw  = tk && (m_cnt == 3599);
            np  = (m_st == 0) ? 0 : (m_st == 2) ? m_presc : (tk ? 0 : m_presc + 1);
            case (m_st)
                0: if (ds) ns = 1;
                1: if (ds) ns = 2; else if (dl) begin ns = 3; nsn = m_cnt; end
                2: if (ds) ns = 1; else if (dc) begin ns = 0; nc = 0; np = 0; end
                default: if (dl) ns = 1; else if (ds) ns = 2;
            endcase
            m_st = ns; m_presc = np; m_cnt = nc; m_snap = nsn;
            m_ps = s & ~m_hs; m_pl = l & ~m_hl; m_pc = c & ~m_hc;
            m_hs = s; m_hl = l; m_hc = c;
            e.digits     = (ns == 3) ? to_bcd(nsn) : to_bcd(nc);
            e.running    = (ns == 1 || ns == 3);
            e.lap_active = (ns == 3);
            e.wrap       = nw;
        end
        sb.push_back(e);
    endtask

    task automatic step(input logic s, input logic l, input logic c, input logic r);
        exp_t e;
        btn_start = s; btn_lap = l; btn_clear = c; reset = r;
        model_edge(s, l, c, r);
        @(posedge clk);
        #1;
        cyc++;
        e = sb.pop_front();
        checks++;
        assert ({dut_digits(), running, lap_active, wrap} === e) else begin
            failures++;
            $error("FAIL sb cycle=%0d got=%h exp=%h", cyc,
                   {dut_digits(), running, lap_active, wrap}, e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic press(input logic s, input logic l, input logic c);
        step(s, l, c, 0);
        step(0, 0, 0, 0);
    endtask

    task automatic wait_model(input int cnt, input int ph, input int budget);
        int n = 0;
        while (!(m_cnt == cnt && m_presc == ph) && n < budget) begin
            step(0, 0, 0, 0);
            n++;
        end
        if (!(m_cnt == cnt && m_presc == ph)) begin
            checks++;
            failures++;
            $error("FAIL timeout_wait got_cnt=%0d exp_cnt=%0d", m_cnt, cnt);
        end
    endtask

    int   wraps, n_step, c0;
    logic seen_max;

    initial begin
        btn_start = 0; btn_lap = 0; btn_clear = 0; reset = 1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        wraps = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0);
            if (wrap) wraps++;
        end
        chk("idle_digits", {16'h0, dut_digits()}, 32'h0);
        chk("idle_running", {31'h0, running}, 32'h0);
        chk("idle_wrap_count", wraps, 0);

        // Start, with the button held for 10 cycles
        step(1, 0, 0, 0);
        chk("start_not_yet", {31'h0, running}, 32'h0);
        step(1, 0, 0, 0);
        chk("start_running", {31'h0, running}, 32'h1);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
        chk("held_no_toggle", {31'h0, running}, 32'h1);

        // Pause at 00:07 and check the fractional second survives
        wait_model(7, 0, 60);
        press(1, 0, 0);
        idle(20);
        chk("pause_digits", {16'h0, dut_digits()}, 32'h0007);
        chk("pause_running", {31'h0, running}, 32'h0);
        press(1, 0, 0);
        chk("resume_running", {31'h0, running}, 32'h1);
        n_step = 0;
        while (sec_o == 4'd7 && n_step < 10) begin
            step(0, 0, 0, 0);
            n_step++;
        end
        chk("resume_first_tick", n_step, 2);

        wait_model(10, 0, 40);
        chk("sec_carry", {16'h0, dut_digits()}, 32'h0010);

        // Lap at 00:12
        wait_model(12, 0, 40);
        press(0, 1, 0);
        chk("lap_active", {31'h0, lap_active}, 32'h1);
        idle(24);
        chk("lap_frozen", {16'h0, dut_digits()}, 32'h0012);
        chk("lap_running", {31'h0, running}, 32'h1);
        press(0, 1, 0);
        chk("lap_release", {31'h0, lap_active}, 32'h0);
        chk("lap_live", {16'h0, dut_digits()}, {16'h0, to_bcd(m_cnt)});

        // Pause then clear
        press(1, 0, 0);
        press(0, 0, 1);
        chk("clear_digits", {16'h0, dut_digits()}, 32'h0);
        chk("clear_running", {31'h0, running}, 32'h0);

        // Full-hour wrap
        press(1, 0, 0);
        wraps = 0;
        seen_max = 0;
        for (int i = 0; i < 14410; i++) begin
            step(0, 0, 0, 0);
            if (wrap) wraps++;
            if (dut_digits() == 16'h5959) seen_max = 1;
        end
        chk("wrap_pulses", wraps, 1);
        chk("wrap_seen_5959", {31'h0, seen_max}, 32'h1);
        chk("wrap_running", {31'h0, running}, 32'h1);

        // Start + clear together in PAUSE: clear wins
        press(1, 0, 0);
        press(1, 0, 1);
        chk("prio_digits", {16'h0, dut_digits()}, 32'h0);
        chk("prio_running", {31'h0, running}, 32'h0);

        // Start press landing on a tick cycle
        press(1, 0, 0);
        idle(5);
        wait_model(m_cnt, TD - 2, 8);
        c0 = m_cnt;
        press(1, 0, 0);
        chk("collide_count", {16'h0, dut_digits()}, {16'h0, to_bcd(c0 + 1)});
        chk("collide_paused", {31'h0, running}, 32'h0);
        idle(8);
        chk("collide_hold", {16'h0, dut_digits()}, {16'h0, to_bcd(c0 + 1)});

        // Reset during LAP
        press(1, 0, 0);
        press(0, 1, 0);
        chk("pre_reset_lap", {31'h0, lap_active}, 32'h1);
        step(0, 0, 0, 1);
        chk("reset_outputs", {16'h0, dut_digits(), 13'h0, running, lap_active, wrap}, 32'h0);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
